sc_et_counter: RTL and testbench

// Stochastic-to-binary converter with early termination: the receiving end of the

---
 rtl/sc_pkg.sv | 15 +
 rtl/sc_et_lane.sv | 40 ++++
 rtl/sc_et_counter.sv | 115 +++++++++++
 tb/tb_sc_et_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared stochastic-computing types: the result count width and the
// early-termination converter state encoding.
package sc_pkg;

    localparam int SC_W_DEFAULT = 8;

    typedef logic [SC_W_DEFAULT:0] sc_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } sc_et_state_e;

endpackage

// File: rtl/sc_et_lane.sv
// One stream of the early-termination converter: the ones counter plus the
// compare that decides whether the top P result bits can still change.
module sc_et_lane #(
    parameter int W = 8,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic         x,
    input  logic [W:0]   beats_next,
    output logic [W:0]   cnt_next,
    output logic [W:0]   cnt_trunc,
    output logic         resolved_next
);

    localparam int SH = W - P;
    localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

    logic [W:0] cnt;
    logic [W:0] hi;

    // lo and hi bound the final count if every remaining beat is 0 or 1
    always_comb begin
        cnt_next      = cnt + {{W{1'b0}}, x};
        hi            = cnt_next + (FULL - beats_next);
        resolved_next = ((cnt_next >> SH) == (hi >> SH));
        cnt_trunc     = (cnt_next >> SH) << SH;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/sc_et_counter.sv
// Stochastic-to-binary converter: counts ones on N streams over up to 2^W
// valid beats, stopping early once every stream's top P bits are settled.
module sc_et_counter
    import sc_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 2,
    parameter int P     = 4,
    parameter bit ET_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [N-1:0]         Xs,
    output logic [N-1:0][W:0]    Bzs,
    output logic [N-1:0]         resolved,
    output logic                 busy,
    output logic                 done,
    output logic                 early,
    output logic [W:0]           beats_used
);

    localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

    sc_et_state_e state;
    logic [W:0]   beats;
    logic [W:0]   beats_next;
    logic         beat_en;
    logic         full_hit;
    logic         early_hit;
    logic         terminate;

    logic [N-1:0][W:0] cnt_next;
    logic [N-1:0][W:0] cnt_trunc;
    logic [N-1:0]      res_next;

    // A start on the same cycle as a valid beat drops that beat
    always_comb begin
        beat_en    = (state == COUNT) && in_valid && !start;
        beats_next = beats + {{W{1'b0}}, 1'b1};
        full_hit   = (beats_next == FULL);
        early_hit  = ET_EN && (&res_next) && !full_hit;
        terminate  = beat_en && (full_hit || early_hit);
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        sc_et_lane #(
            .W (W),
            .P (P)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .clear         (start),
            .en            (beat_en),
            .x             (Xs[g]),
            .beats_next    (beats_next),
            .cnt_next      (cnt_next[g]),
            .cnt_trunc     (cnt_trunc[g]),
            .resolved_next (res_next[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beats      <= '0;
            Bzs        <= '0;
            resolved   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            early      <= 1'b0;
            beats_used <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state    <= COUNT;
                beats    <= '0;
                resolved <= '0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    COUNT: begin
                        if (beat_en) begin
                            beats    <= beats_next;
                            resolved <= res_next;
                            if (terminate) begin
                                state      <= DONE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                early      <= early_hit;
                                beats_used <= beats_next;
                                resolved   <= '0;
                                for (int i = 0; i < N; i++) begin
                                    Bzs[i] <= early_hit ? cnt_trunc[i] : cnt_next[i];
                                end
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sc_et_counter.sv
// Directed bench for sc_et_counter at W=8, P=2, N=2: one instance with early
// termination, one running full windows, driven by the same inputs.
module tb_sc_et_counter;
    import sc_pkg::*;

    localparam int W = 8;
    localparam int N = 2;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic in_valid;
    logic [N-1:0] Xs;

    logic [N-1:0][W:0] bz_a, bz_b;
    logic [N-1:0]      res_a, res_b;
    logic              busy_a, busy_b;
    logic              done_a, done_b;
    logic              early_a, early_b;
    logic [W:0]        used_a, used_b;

    int errors = 0;
    int checks = 0;
    int doneCount = 0;

    typedef struct {
        int      dutSel;
        int      mode;
        bit      toggle;
        int      expBeats;
        bit      expEarly;
        sc_cnt_t expBz1;
        sc_cnt_t expBz0;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    sc_et_counter #(.W(W), .N(N), .P(P), .ET_EN(1'b1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .Xs         (Xs),
        .Bzs        (bz_a),
        .resolved   (res_a),
        .busy       (busy_a),
        .done       (done_a),
        .early      (early_a),
        .beats_used (used_a)
    );

    sc_et_counter #(.W(W), .N(N), .P(P), .ET_EN(1'b0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .Xs         (Xs),
        .Bzs        (bz_b),
        .resolved   (res_b),
        .busy       (busy_b),
        .done       (done_b),
        .early      (early_b),
        .beats_used (used_b)
    );

    // Stream patterns indexed by valid-beat number, chosen for easy hand counts
    function automatic logic [1:0] genXs(input int mode, input int idx);
        logic [1:0] v;
        v = 2'b00;
        case (mode)
            1: v = 2'b10;
            2: v = {(idx % 4) != 0, (idx % 2) == 1};
            3: v = 2'b11;
            5: v = {1'b0, idx < 64};
            6: v = {1'b0, idx < 100};
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Opens a window, feeds beats until the selected instance pulses done, then
    // checks the latched results and that done lasts exactly one cycle.
    task automatic applyStimulus(input string label, input int dutSel, input int mode,
                                 input bit toggle, input int expBeats, input bit expEarly,
                                 input int expBz1, input int expBz0);
        int  fed;
        int  cycles;
        bit  seen;
        bit  selDone;
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        fed      = 0;
        cycles   = 0;
        seen     = 1'b0;
        while (!seen && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            start   = 1'b0;
            selDone = (dutSel == 0) ? done_a : done_b;
            if (selDone) begin
                seen = 1'b1;
            end else begin
                in_valid = toggle ? cycles[0] : 1'b1;
                if (in_valid) begin
                    Xs = genXs(mode, fed);
                    fed++;
                end
            end
        end
        in_valid = 1'b0;
        checkOutput({label, ".doneSeen"}, int'(seen), 1);
        if (seen) begin
            checkOutput({label, ".beatsFed"}, fed, expBeats);
            if (dutSel == 0) begin
                checkOutput({label, ".beatsUsed"}, int'(used_a), expBeats);
                checkOutput({label, ".early"}, int'(early_a), int'(expEarly));
                checkOutput({label, ".bz1"}, int'(bz_a[1]), expBz1);
                checkOutput({label, ".bz0"}, int'(bz_a[0]), expBz0);
                checkOutput({label, ".busy"}, int'(busy_a), 0);
                @(negedge clk);
                checkOutput({label, ".donePulse"}, int'(done_a), 0);
            end else begin
                checkOutput({label, ".beatsUsed"}, int'(used_b), expBeats);
                checkOutput({label, ".early"}, int'(early_b), int'(expEarly));
                checkOutput({label, ".bz1"}, int'(bz_b[1]), expBz1);
                checkOutput({label, ".bz0"}, int'(bz_b[0]), expBz0);
                checkOutput({label, ".busy"}, int'(busy_b), 0);
                @(negedge clk);
                checkOutput({label, ".donePulse"}, int'(done_b), 0);
            end
        end
    endtask

    task automatic feedBeats(input int mode, input int n);
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            Xs       = genXs(mode, i);
            @(negedge clk);
            if (done_a) doneCount++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        Xs       = 2'b00;

        // Expected windows: hi = cnt + 256 - beats, resolved when cnt>>6 == hi>>6
        vecs[0] = '{0, 0, 1'b0, 193, 1'b1, 0,   0};
        vecs[1] = '{0, 1, 1'b0, 256, 1'b0, 256, 0};
        vecs[2] = '{1, 2, 1'b0, 256, 1'b0, 192, 128};
        vecs[3] = '{0, 0, 1'b1, 193, 1'b1, 0,   0};
        vecs[4] = '{0, 3, 1'b0, 256, 1'b0, 256, 256};
        vecs[5] = '{0, 5, 1'b0, 193, 1'b1, 0,   64};
        vecs[6] = '{0, 6, 1'b0, 229, 1'b1, 0,   64};
        vecs[7] = '{1, 0, 1'b0, 256, 1'b0, 0,   0};

        repeat (2) @(negedge clk);
        checkOutput("reset.busy", int'(busy_a), 0);
        checkOutput("reset.done", int'(done_a), 0);
        checkOutput("reset.early", int'(early_a), 0);
        checkOutput("reset.beatsUsed", int'(used_a), 0);
        checkOutput("reset.bzs", int'(bz_a), 0);
        checkOutput("reset.resolved", int'(res_a), 0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            applyStimulus($sformatf("vec%0d", k), vecs[k].dutSel, vecs[k].mode,
                          vecs[k].toggle, vecs[k].expBeats, vecs[k].expEarly,
                          int'(vecs[k].expBz1), int'(vecs[k].expBz0));
        end

        doneCount = 0;
        feedBeats(0, 100);
        checkOutput("midReset.busyBefore", int'(busy_a), 1);
        checkOutput("midReset.noDone", doneCount, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midReset.busy", int'(busy_a), 0);
        checkOutput("midReset.beatsUsed", int'(used_a), 0);
        checkOutput("midReset.bzs", int'(bz_a), 0);
        checkOutput("midReset.resolved", int'(res_a), 0);
        applyStimulus("afterReset", 0, 0, 1'b0, 193, 1'b1, 0, 0);

        doneCount = 0;
        feedBeats(3, 50);
        checkOutput("restart.busy", int'(busy_a), 1);
        checkOutput("restart.noDone", doneCount, 0);
        applyStimulus("restart", 0, 0, 1'b0, 193, 1'b1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
